mips_mem_arbiter: RTL
=====================

Name: mips_mem_arbiter

Overview:
- Shares one Avalon-style memory bus between the instruction-fetch port and the data port of the multi-cycle MIPS core.
- Used by the bus-variant CPU wrapper so that the Harvard datapath runs unchanged against a single memory with waitrequest.
- Sequences each access as grant, bus phase, then response, and stalls requesters until their response is delivered.

Parameters:
- ADDR_W, 32, address width of ports and bus.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_DATA_RUN, 4, max consecutive data grants while an instruction request is pending (starvation guard); range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_req  in  1  instruction fetch request, level, held until i_ready
- i_address  in  ADDR_W  fetch address
- i_readdata  out  DATA_W  fetched word, valid while i_ready=1
- i_ready  out  1  one-cycle completion pulse for fetch
- d_read  in  1  data read request, level, held until d_ready
- d_write  in  1  data write request, level, held until d_ready
- d_address  in  ADDR_W  data address
- d_writedata  in  DATA_W  store data
- d_byteenable  in  DATA_W/8  store/load lane enables
- d_readdata  out  DATA_W  load data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- bus_address  out  ADDR_W  bus address
- bus_read  out  1  bus read strobe
- bus_write  out  1  bus write strobe
- bus_writedata  out  DATA_W  bus write data
- bus_byteenable  out  DATA_W/8  bus lane enables
- bus_readdata  in  DATA_W  bus read data
- bus_waitrequest  in  1  bus stall
- busy  out  1  high in any state other than IDLE
- grant_data  out  1  1 when the current or most recent grant is the data port

Behaviour:
- Reset (sync): state=IDLE. bus_read, bus_write, i_ready, d_ready, busy, grant_data=0. bus_address, bus_writedata, bus_byteenable, i_readdata, d_readdata=0. Run counter=0.
- Reset mid-transaction aborts at the next edge with no ready pulse. Memory models are reset together with the arbiter.
- All outputs are registered.
- States:
  - IDLE: sample requests. If any is pending, latch the winner's address, writedata and byteenable onto the bus regs, assert bus_read or bus_write, go to ACCESS. Otherwise stay.
  - ACCESS: hold all bus outputs stable while bus_waitrequest=1. On the first cycle with bus_waitrequest=0:
    - capture bus_readdata into the winner's readdata register (reads only);
    - drop strobes at the next edge;
    - go to RESP.
  - RESP: winner's ready=1 for exactly this cycle, then go to IDLE. Requesters see ready and must drop req by the following cycle. A req still high in IDLE is a new request.
- Arbitration in IDLE:
  - Data has priority over fetch.
  - If both are pending and run counter = MAX_DATA_RUN, fetch wins.
  - Run counter increments on each data grant while i_req=1. It clears on any fetch grant, and on a data grant with i_req=0.
- Fetch access: bus_read=1, bus_byteenable=all ones.
- Data access: d_write=1 yields bus_write; else bus_read.
  - d_read and d_write both high is illegal; write wins and no read data is returned (d_readdata unchanged).
- bus_address is the requester address with bits [1:0] forced to 0. The byte lane is conveyed only via byteenable.
- Latency: with waitrequest=0, request in IDLE at cycle N gives strobe at N+1, ready pulse at N+2, and next grant earliest at N+3. Each waitrequest cycle adds one.
- Non-winner readdata registers hold their previous value.
- Requests changing while ACCESS/RESP are ignored; latched values are used.
- busy=1 in ACCESS and RESP.

Test Plan:
- Reset then i_req=1, i_address=0xBFC00002, waitrequest=0, bus_readdata=0x24020005:
  - required: bus_address=0xBFC00000 with bus_read one cycle later;
  - required: i_readdata=0x24020005, i_ready pulse at cycle +2, no d_ready.
- d_write=1, d_address=0x1000, d_writedata=0xDEADBEEF, d_byteenable=0x3, waitrequest high for 3 cycles:
  - required: strobes and fields stable for 4 ACCESS cycles;
  - required: d_ready pulse one cycle after waitrequest falls.
- i_req and d_read asserted together, MAX_DATA_RUN=4:
  - required: data granted first;
  - required: data re-asserted back-to-back 4 times, then fetch granted on the 5th arbitration and the counter cleared.
- d_read and d_write both high, d_readdata previously 0x11111111:
  - required: bus_write only;
  - required: d_readdata stays 0x11111111 at d_ready.
- Reset asserted during ACCESS with waitrequest=1:
  - required: next cycle all strobes 0, busy=0, no ready pulse;
  - required: a subsequent fetch completes normally.
- Back-to-back fetches with i_req held continuously:
  - required: exactly one i_ready per 3-cycle transaction;
  - required: no duplicate bus strobes in RESP.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the MIPS fetch and data ports onto one Avalon-style bus: grant, bus phase, then a one-cycle ready.
// Latency is 2 cycles plus one per waitrequest cycle; requesters are stalled until their ready pulse.
module mips_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_address,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_ready,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_ready,
  output logic [ADDR_W-1:0]   bus_address,
  output logic                bus_read,
  output logic                bus_write,
  output logic [DATA_W-1:0]   bus_writedata,
  output logic [DATA_W/8-1:0] bus_byteenable,
  input  logic [DATA_W-1:0]   bus_readdata,
  input  logic                bus_waitrequest,
  output logic                busy,
  output logic                grant_data
);

  localparam logic [3:0]        RUN_MAX   = 4'(MAX_DATA_RUN);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] run_cnt;
  logic       data_pend;
  logic       fetch_win;
  logic       any_req;

  always_comb begin
    data_pend = d_read | d_write;
    any_req   = i_req | data_pend;
    // Fetch only beats a pending data request once data has had its full run.
    fetch_win = i_req && (!data_pend || run_cnt == RUN_MAX);
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (!bus_waitrequest) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_address    <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_writedata  <= '0;
      bus_byteenable <= '0;
      i_readdata     <= '0;
      d_readdata     <= '0;
      i_ready        <= 1'b0;
      d_ready        <= 1'b0;
      busy           <= 1'b0;
      grant_data     <= 1'b0;
      run_cnt        <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            busy       <= 1'b1;
            grant_data <= !fetch_win;
            if (fetch_win) begin
              bus_address    <= i_address & WORD_MASK;
              bus_read       <= 1'b1;
              bus_write      <= 1'b0;
              bus_byteenable <= '1;
              run_cnt        <= '0;
            end else begin
              bus_address    <= d_address & WORD_MASK;
              bus_writedata  <= d_writedata;
              bus_byteenable <= d_byteenable;
              // A simultaneous read and write is treated as a write only.
              bus_write      <= d_write;
              bus_read       <= !d_write;
              run_cnt        <= i_req ? run_cnt + 4'd1 : 4'd0;
            end
          end
        end
        ACCESS: begin
          if (!bus_waitrequest) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            if (grant_data) begin
              d_ready <= 1'b1;
              if (bus_read) d_readdata <= bus_readdata;
            end else begin
              i_ready    <= 1'b1;
              i_readdata <= bus_readdata;
            end
          end
        end
        RESP: busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
